// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : shared 640x480@60 timing constants, coordinate type, helper
// Rev 1.0
// ============================================================================
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 10;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;

  localparam int unsigned H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START  = H_DISPLAY + H_FP;
  localparam int unsigned HS_END    = HS_START + H_SYNC;
  localparam int unsigned VS_START  = V_DISPLAY + V_FP;
  localparam int unsigned VS_END    = VS_START + V_SYNC;

  typedef logic [COORD_W-1:0] coord_t;

  // Half-open window test [lo, hi) on a screen coordinate.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_sync_delay_line.sv
`default_nettype none
// ============================================================================
// sync_delay_line : DEPTH-stage shift register with async reset to RESET_VAL
// Rev 1.0
// ============================================================================
module sync_delay_line #(
  parameter int unsigned          DEPTH     = 2,
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = din;
    for (int i = 1; i < int'(DEPTH); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= {DEPTH{RESET_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : pixel counters, sync/blank decode, latency-matched outputs
// Rev 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
  parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP      = vga_timing_pkg::V_BP,
  parameter logic        SYNC_POL  = 1'b0,
  parameter int unsigned PIPE_DLY  = 2
) (
  input  logic       vga_clock,
  input  logic       reset,
  output logic [9:0] pixel_column,
  output logic [9:0] pixel_row,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       video_on,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  import vga_timing_pkg::*;

  localparam int unsigned H_TOT = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam coord_t COL_LAST = coord_t'(H_TOT - 1);
  localparam coord_t ROW_LAST = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_LO    = coord_t'(H_DISPLAY + H_FP);
  localparam coord_t HS_HI    = coord_t'(H_DISPLAY + H_FP + H_SYNC);
  localparam coord_t VS_LO    = coord_t'(V_DISPLAY + V_FP);
  localparam coord_t VS_HI    = coord_t'(V_DISPLAY + V_FP + V_SYNC);

  // Raw-decode bit order through the delay line.
  localparam logic [3:0] LINE_RESET = {~SYNC_POL, ~SYNC_POL, 1'b0, 1'b0};

  if (H_TOT > 1023 || V_TOT > 1023) begin : g_total_check
    $error("vga_timing_gen: H_TOT=%0d / V_TOT=%0d exceed the 10-bit counters", H_TOT, V_TOT);
  end

  if (PIPE_DLY < 1 || PIPE_DLY > 7) begin : g_dly_check
    $error("vga_timing_gen: PIPE_DLY=%0d outside 1..7", PIPE_DLY);
  end

  coord_t     col_q, col_d;
  coord_t     row_q, row_d;
  logic [7:0] frame_count_q, frame_count_d;

  logic       h_wrap;
  logic       v_wrap;
  logic       hs_on, vs_on;
  logic [3:0] raw;
  logic [3:0] line_out;

  always_comb begin
    h_wrap        = (col_q == COL_LAST);
    v_wrap        = (row_q == ROW_LAST);
    col_d         = h_wrap ? '0 : col_q + 10'd1;
    row_d         = row_q;
    frame_count_d = frame_count_q;
    // Row advances only on the line wrap; a frame completes on the joint wrap.
    if (h_wrap) begin
      row_d = v_wrap ? '0 : row_q + 10'd1;
      if (v_wrap) begin
        frame_count_d = frame_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      col_q         <= '0;
      row_q         <= '0;
      frame_count_q <= '0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    hs_on  = in_window(col_q, HS_LO, HS_HI);
    vs_on  = in_window(row_q, VS_LO, VS_HI);
    raw[3] = hs_on ? SYNC_POL : ~SYNC_POL;
    raw[2] = vs_on ? SYNC_POL : ~SYNC_POL;
    raw[1] = in_window(col_q, '0, H_VIS) && in_window(row_q, '0, V_VIS);
    raw[0] = (col_q == '0) && (row_q == '0);
  end

  sync_delay_line #(
    .DEPTH     (PIPE_DLY),
    .WIDTH     (4),
    .RESET_VAL (LINE_RESET)
  ) u_sync_delay_line (
    .clk   (vga_clock),
    .rst_n (reset),
    .din   (raw),
    .dout  (line_out)
  );

  assign pixel_column = col_q;
  assign pixel_row    = row_q;
  assign frame_count  = frame_count_q;
  assign horiz_sync   = line_out[3];
  assign vert_sync    = line_out[2];
  assign video_on     = line_out[1];
  assign frame_start  = line_out[0];

endmodule
`default_nettype wire
